alu_sequencer: RTL and testbench
================================

# alu_sequencer

Sequencing stage directly upstream of the 4-bit combinational ALU. Accepts a stream of instructions over a valid/ready handshake, buffers them in a small FIFO, keeps a 4-bit accumulator and a 4×4-bit register file, drives the ALU operand and opcode inputs from registers, and captures the ALU result and flags back into the accumulator. It turns the stateless ALU into a usable accumulator datapath.

## Interface
Parameters:
- FIFO_DEPTH, 2, instruction buffer depth; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  buffer can accept this cycle.
- instr_kind  in  2  00 ALU-imm, 01 ALU-reg, 10 STORE acc→reg, 11 LOAD imm→acc.
- instr_op  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 PASS-B; 011/100/101 yield 0.
- instr_idx  in  2  register index (ALU-reg source, STORE destination).
- instr_imm  in  4  immediate operand.
- alu_a  out  4  registered ALU operand A (accumulator).
- alu_b  out  4  registered ALU operand B.
- alu_op  out  3  registered ALU opcode.
- alu_result  in  4  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry flag.
- acc  out  4  accumulator.
- zero  out  1  registered zero flag.
- carry  out  1  registered carry flag.
- done  out  1  one-cycle pulse per retired instruction.
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.

At the top level, the vector ALU ports are bit-split onto the ALU's scalar pins.

## Operation
- Reset values: acc=0, all regs=0, zero=1, carry=0, alu_a/alu_b/alu_op=0, done=0, busy=0, FIFO empty. instr_ready=0 while rst is high.
- Push: a transfer occurs when instr_valid && instr_ready. instr_ready = !fifo_full. Instructions retire strictly in order.
- FSM states: IDLE, EXEC.
  - IDLE with FIFO non-empty: pop the head.
  - LOAD: acc←imm; zero←(imm==0); carry←0; stay in IDLE.
  - STORE: reg[idx]←acc; flags unchanged; stay in IDLE.
  - ALU-imm / ALU-reg: alu_a←acc; alu_b←imm or reg[idx], with reg[idx] read at pop time; alu_op←op; go to EXEC.
  - EXEC: capture acc←alu_result, zero←alu_zero, carry←alu_carry; go to IDLE.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- Simultaneous push and pop are allowed when the FIFO is not full. When full, instr_ready=0 and the pop frees a slot visible the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra wrap bit to distinguish full from empty.
- Reset mid-operation: state→IDLE, FIFO flushed, in-flight instruction discarded, no done pulse.

## Timing
- An instruction pushed at edge N is visible at the FIFO head in cycle N+1. No same-cycle bypass.
- LOAD/STORE popped in cycle t: result visible and done=1 in cycle t+1. The next pop may occur in cycle t+1.
- ALU instruction popped in cycle t:
  - ALU drives are valid in cycle t+1 (EXEC); the ALU settles combinationally.
  - Capture occurs at the end of t+1; acc, flags and done=1 are visible in cycle t+2.
  - The next pop may occur in cycle t+2.
- Throughput: 1 instruction/cycle for LOAD/STORE, 1 per 2 cycles for ALU instructions.

## Structure
- Shared package alu_pkg: opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB), instruction-kind enum, FSM state enum, and a packed instruction struct (kind, op, idx, imm).
- Sub-module instr_fifo: parameterised synchronous FIFO of the packed instruction struct, with push/pop/full/empty.
- Sequencer FSM, accumulator, register file and flag registers live in alu_sequencer.

## Test plan
- Reset, then LOAD imm 5 → cycle after pop: acc=5, zero=0, carry=0, done=1 for one cycle.
- LOAD 9, then ALU-imm ADD 8 → done two cycles after the ADD pop; acc=1, carry=1, zero=0.
- LOAD 3; STORE r2; ALU-reg SUB r2 → acc=0, zero=1, carry=1 (ALU carry of 0011+1101); r2 remains 3.
- Hold instr_valid for 4 back-to-back LOADs/ADDs with FIFO_DEPTH=2 → instr_ready drops when 2 entries are buffered; all 4 retire in order; final acc matches the golden model.
- ALU-imm with op 011, imm 7, acc 6 → acc=0, zero=1, carry=0.
- Assert rst during EXEC of an ADD with 1 instruction queued → next cycle acc=0, zero=1, FIFO empty, no done pulse, instr_ready=1 after rst drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer datapath.
//   - ALU opcode encodings driven on alu_op
//   - instruction kind and sequencer state enums
//   - packed instruction word as stored in the instruction FIFO
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    KIND_ALU_IMM = 2'b00,
    KIND_ALU_REG = 2'b01,
    KIND_STORE   = 2'b10,
    KIND_LOAD    = 2'b11
  } kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] op;
    logic [1:0] idx;
    logic [3:0] imm;
  } instr_t;

  // ALU-imm and ALU-reg both need the two-cycle EXEC path.
  function automatic logic is_alu_kind(input kind_e k);
    return (k == KIND_ALU_IMM) || (k == KIND_ALU_REG);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction stream valid/ready bus into the ALU sequencer.
//   master : instruction source (drives valid and the instruction fields)
//   slave  : sequencer (drives ready)
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_kind;
  logic [2:0] instr_op;
  logic [1:0] instr_idx;
  logic [3:0] instr_imm;

  modport master (
    output instr_valid, instr_kind, instr_op, instr_idx, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_kind, instr_op, instr_idx, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer_instr_fifo.sv
// instr_fifo: synchronous FIFO of packed instructions.
//   clk, rst  : clock, synchronous active-high reset (flushes pointers)
//   push_i    : write wdata_i (ignored when full)
//   pop_i     : advance the head (ignored when empty)
//   wdata_i   : instruction to enqueue
//   rdata_o   : instruction at the head (valid when !empty_o)
//   full_o    : no free slot
//   empty_o   : nothing buffered
module instr_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  instr_t wdata_i,
  output instr_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  instr_t     mem_q [DEPTH];
  // MSB is a wrap bit so equal indices can be told apart as full or empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accumulator datapath wrapped around an external
// combinational 4-bit ALU.
//   clk, rst          : clock, synchronous active-high reset
//   instr_bus (slave) : instruction stream (valid/ready, kind/op/idx/imm)
//   alu_a/alu_b/alu_op: registered ALU operand and opcode drives
//   alu_result/zero/carry : ALU outputs, captured at the end of EXEC
//   acc, zero, carry  : accumulator and registered flags
//   done              : one-cycle pulse per retired instruction
//   busy              : not IDLE, or instructions still buffered
//
// state   | meaning
// IDLE    | pop head if present; LOAD/STORE retire here in one cycle
// EXEC    | ALU inputs are driven; capture result and flags, back to IDLE
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        instr_bus,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [2:0]            alu_op,
  input  logic [3:0]            alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  output logic [3:0]            acc,
  output logic                  zero,
  output logic                  carry,
  output logic                  done,
  output logic                  busy
);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       done_q, done_d;

  instr_t     push_instr;
  instr_t     head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign instr_bus.instr_ready = !fifo_full && !rst;
  assign fifo_push  = instr_bus.instr_valid && instr_bus.instr_ready;
  assign push_instr = '{kind: kind_e'(instr_bus.instr_kind),
                        op:   instr_bus.instr_op,
                        idx:  instr_bus.instr_idx,
                        imm:  instr_bus.instr_imm};

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_instr),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    regs_d   = regs_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_alu_kind(head.kind)) begin
            alu_a_d  = acc_q;
            // Register operand is sampled now, so a STORE retired last
            // cycle is already visible here.
            alu_b_d  = (head.kind == KIND_ALU_REG) ? regs_q[head.idx] : head.imm;
            alu_op_d = head.op;
            state_d  = ST_EXEC;
          end else if (head.kind == KIND_LOAD) begin
            acc_d   = head.imm;
            zero_d  = (head.imm == 4'h0);
            carry_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            regs_d[head.idx] = acc_q;
            done_d           = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        acc_d   = alu_result;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= 4'h0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      regs_q   <= '{default: 4'h0};
      alu_a_q  <= 4'h0;
      alu_b_q  <= 4'h0;
      alu_op_q <= 3'b000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      regs_q   <= regs_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      done_q   <= done_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign acc    = acc_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign done   = done_q;
  assign busy   = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed instructions with hand-computed
// results, a combinational ALU stand-in, and a done-driven scoreboard.
module tb_alu_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [1:0] kind;
    logic [2:0] op;
    logic [1:0] idx;
    logic [3:0] imm;
    logic [5:0] res;  // {acc, zero, carry}
    int         lat;  // edges from push to done; 0 = not checked
  } vec_t;

  typedef struct {
    logic [5:0] res;
    int         cyc;
    int         lat;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_result, acc;
  logic [2:0] alu_op;
  logic       alu_zero, alu_carry, zero, carry, done, busy;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  saw_not_ready = 1'b0;
  sb_t exp_q [$];

  alu_sequencer_if bus ();

  alu_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_bus  (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .acc        (acc),
    .zero       (zero),
    .carry      (carry),
    .done       (done),
    .busy       (busy)
  );

  // Stand-in for the combinational 4-bit ALU.
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (alu_op)
      OP_AND:   t = {1'b0, alu_a & alu_b};
      OP_OR:    t = {1'b0, alu_a | alu_b};
      OP_ADD:   t = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:   t = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      OP_PASSB: t = {1'b0, alu_b};
      default:  t = 5'd0;
    endcase
    alu_result = t[3:0];
    alu_carry  = t[4];
    alu_zero   = (t[3:0] == 4'h0);
  end

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input logic [2:0] op,
                              input logic [1:0] idx, input logic [3:0] imm,
                              input logic [3:0] e_acc, input logic e_z,
                              input logic e_c, input int lat);
    vec_t v;
    v.kind = kind; v.op = op; v.idx = idx; v.imm = imm;
    v.res  = {e_acc, e_z, e_c};
    v.lat  = lat;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input vec_t v);
    int  g;
    sb_t e;
    bus.instr_valid = 1'b1;
    bus.instr_kind  = v.kind;
    bus.instr_op    = v.op;
    bus.instr_idx   = v.idx;
    bus.instr_imm   = v.imm;
    g = 0;
    while (!bus.instr_ready && g < 100) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      g++;
    end
    if (!bus.instr_ready) begin
      check("push_timeout", 16'd0, 16'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res = v.res;
    e.cyc = cyc;
    e.lat = v.lat;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_wait();
    int g;
    bus.instr_valid = 1'b0;
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) check("idle_timeout", 16'd1, 16'd0);
  endtask

  task automatic run1(input vec_t v);
    send(v);
    idle_wait();
  endtask

  // Scoreboard monitor: every done pulse retires the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 16'd1, 16'd0);
        end else begin
          e = exp_q.pop_front();
          check("retire_acc_z_c", 16'(e.res), {10'd0, acc, zero, carry});
          if (e.lat > 0) check("retire_latency", 16'(cyc - e.cyc), 16'(e.lat));
        end
      end
    end
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_kind  = 2'b00;
    bus.instr_op    = 3'b000;
    bus.instr_idx   = 2'b00;
    bus.instr_imm   = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_rst", 16'(bus.instr_ready), 16'd0);
    check("rst_acc", 16'(acc), 16'd0);
    check("rst_flags", {14'd0, zero, carry}, 16'b10);
    check("rst_alu_drv", {5'd0, alu_a, alu_b, alu_op}, 16'd0);
    check("rst_done_busy", {14'd0, done, busy}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 16'(bus.instr_ready), 16'd1);

    // Isolated instructions: LOAD/STORE retire 1 edge after push+pop, ALU 2.
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd5,  4'd5,  1'b0, 1'b0, 1));
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd9,  4'd9,  1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_IMM, OP_ADD,   2'd0, 4'd8,  4'd1,  1'b0, 1'b1, 2));
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd3,  4'd3,  1'b0, 1'b0, 1));
    run1(mk(KIND_STORE,   3'b000,   2'd2, 4'd0,  4'd3,  1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_REG, OP_SUB,   2'd2, 4'd0,  4'd0,  1'b1, 1'b1, 2));
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd6,  4'd6,  1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_IMM, 3'b011,   2'd0, 4'd7,  4'd0,  1'b1, 1'b0, 2));
    run1(mk(KIND_ALU_REG, OP_PASSB, 2'd2, 4'hF,  4'd3,  1'b0, 1'b0, 2));
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd12, 4'd12, 1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_IMM, OP_OR,    2'd0, 4'd3,  4'd15, 1'b0, 1'b0, 2));
    run1(mk(KIND_ALU_IMM, OP_AND,   2'd0, 4'd10, 4'd10, 1'b0, 1'b0, 2));
    run1(mk(KIND_ALU_IMM, OP_ADD,   2'd0, 4'd6,  4'd0,  1'b1, 1'b1, 2));
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd0,  4'd0,  1'b1, 1'b0, 1));
    run1(mk(KIND_ALU_IMM, OP_SUB,   2'd0, 4'd1,  4'd15, 1'b0, 1'b0, 2));
    run1(mk(KIND_STORE,   3'b000,   2'd1, 4'd0,  4'd15, 1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_REG, OP_ADD,   2'd1, 4'd0,  4'd14, 1'b0, 1'b1, 2));
    check("alu_drv_hold", {5'd0, alu_a, alu_b, alu_op}, {5'd0, 4'd15, 4'd15, OP_ADD});

    // Back-to-back with valid held: the buffer fills and ready drops.
    saw_not_ready = 1'b0;
    send(mk(KIND_LOAD,    3'b000, 2'd0, 4'd2, 4'd2, 1'b0, 1'b0, 0));
    send(mk(KIND_ALU_IMM, OP_ADD, 2'd0, 4'd3, 4'd5, 1'b0, 1'b0, 0));
    send(mk(KIND_ALU_IMM, OP_ADD, 2'd0, 4'd4, 4'd9, 1'b0, 1'b0, 0));
    send(mk(KIND_ALU_IMM, OP_ADD, 2'd0, 4'd9, 4'd2, 1'b0, 1'b1, 0));
    send(mk(KIND_ALU_IMM, OP_ADD, 2'd0, 4'd1, 4'd3, 1'b0, 1'b0, 0));
    idle_wait();
    check("ready_dropped_when_full", 16'(saw_not_ready), 16'd1);

    // Reset while an ADD is in EXEC with one LOAD still buffered.
    run1(mk(KIND_LOAD, 3'b000, 2'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1));
    send(mk(KIND_ALU_IMM, OP_ADD, 2'd0, 4'd2, 4'd3, 1'b0, 1'b0, 0));
    send(mk(KIND_LOAD,    3'b000, 2'd0, 4'd7, 4'd7, 1'b0, 1'b0, 0));
    bus.instr_valid = 1'b0;
    check("busy_before_rst", 16'(busy), 16'd1);
    check("alu_drv_in_exec", {5'd0, alu_a, alu_b, alu_op}, {5'd0, 4'd1, 4'd2, OP_ADD});
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_acc", 16'(acc), 16'd0);
    check("midrst_flags", {14'd0, zero, carry}, 16'b10);
    check("midrst_done_busy", {14'd0, done, busy}, 16'd0);
    check("midrst_ready", 16'(bus.instr_ready), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", 16'(bus.instr_ready), 16'd1);
    check("busy_after_midrst", 16'(busy), 16'd0);
    repeat (4) @(negedge clk);
    run1(mk(KIND_LOAD,    3'b000,   2'd0, 4'd4, 4'd4, 1'b0, 1'b0, 1));
    run1(mk(KIND_ALU_REG, OP_PASSB, 2'd2, 4'hF, 4'd0, 1'b1, 1'b0, 2));

    repeat (3) @(negedge clk);
    check("all_retired", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
